// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the queue entry layout and the PC increment helper.
package fetch_pkg;

   localparam int XLEN      = 32;
   localparam int INSTR_W   = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int DEPTH_DEF = 2;

   function automatic int cnt_w(input int d);
      return $clog2(d + 1);
   endfunction

   localparam int CNT_W = cnt_w(DEPTH_DEF);

   typedef struct packed {
      logic [XLEN-1:0]    pc;
      logic [INSTR_W-1:0] instr;
   } fq_entry_t;

   function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue of {pc, instr} entries with synchronous clear.
// Head is presented directly from storage; zero while empty.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push_i,
   input  fq_entry_t                 din_i,
   input  logic                      pop_i,
   input  logic                      clear_i,
   output fq_entry_t                 dout_o,
   output logic [cnt_w(DEPTH)-1:0]   count_o,
   output logic                      full_o,
   output logic                      empty_o
);

   localparam int CW = cnt_w(DEPTH);
   localparam int PW = $clog2(DEPTH);

   fq_entry_t         mem_q [DEPTH];
   logic [PW-1:0]     rd_q, rd_d;
   logic [PW-1:0]     wr_q, wr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              do_push;
   logic              do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full_o  = (cnt_q == CW'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign count_o = cnt_q;
   assign dout_o  = empty_o ? '0 : mem_q[rd_q];

   always_comb begin
      do_push = push_i && !full_o && !clear_i;
      do_pop  = pop_i && !empty_o && !clear_i;
      rd_d    = rd_q;
      wr_d    = wr_q;
      cnt_d   = cnt_q;
      if (clear_i) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
      end else begin
         if (do_push) wr_d = ptr_inc(wr_q);
         if (do_pop)  rd_d = ptr_inc(rd_q);
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/fetch_unit.sv
// Credit-based instruction fetch with in-order responses and redirect.
// Responses already in flight at a redirect are counted out and dropped.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF,
   parameter int              DEPTH    = DEPTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               redirect_valid,
   input  logic [XLEN-1:0]    redirect_pc,
   output logic               imem_req_valid,
   output logic [XLEN-1:0]    imem_req_addr,
   input  logic               imem_req_ready,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   output logic               if_valid,
   output logic [XLEN-1:0]    if_pc,
   output logic [INSTR_W-1:0] if_instr,
   input  logic               if_ready
);

   localparam int CW = cnt_w(DEPTH);

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
   logic [CW-1:0]   out_q, out_d;
   logic [CW-1:0]   disc_q, disc_d;
   logic [CW-1:0]   q_count;
   logic [CW:0]     credit;
   logic [XLEN-1:0] tgt_pc;
   logic            accept, rsp_ok, keep, drop, pop;
   logic            q_full, q_empty;
   fq_entry_t       head, tail;

   // Queued plus in-flight (including doomed) words must fit the queue.
   assign credit = {1'b0, q_count} + {1'b0, out_q};
   assign imem_req_valid = !rst && !redirect_valid
                         && (credit < (CW+1)'(DEPTH));
   assign imem_req_addr  = fetch_pc_q;
   assign accept = imem_req_valid && imem_req_ready;
   assign rsp_ok = imem_rsp_valid && (out_q != '0);
   assign keep   = rsp_ok && !redirect_valid && (disc_q == '0);
   assign drop   = rsp_ok && !redirect_valid && (disc_q != '0);
   assign pop    = if_valid && if_ready && !redirect_valid;
   assign tgt_pc = redirect_pc & ~XLEN'(3);
   assign tail   = '{pc: rsp_pc_q, instr: imem_rsp_data};

   assign if_valid = !q_empty;
   assign if_pc    = head.pc;
   assign if_instr = head.instr;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rsp_pc_d   = rsp_pc_q;
      disc_d     = disc_q;
      out_d      = out_q + CW'(accept) - CW'(rsp_ok);
      if (redirect_valid) begin
         fetch_pc_d = tgt_pc;
         rsp_pc_d   = tgt_pc;
         disc_d     = out_q - CW'(rsp_ok);
      end else begin
         if (accept) fetch_pc_d = pc_next(fetch_pc_q);
         if (keep)   rsp_pc_d   = pc_next(rsp_pc_q);
         if (drop)   disc_d     = disc_q - CW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q <= RESET_PC;
         rsp_pc_q   <= RESET_PC;
         out_q      <= '0;
         disc_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rsp_pc_q   <= rsp_pc_d;
         out_q      <= out_d;
         disc_q     <= disc_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (keep),
      .din_i   (tail),
      .pop_i   (pop),
      .clear_i (redirect_valid),
      .dout_o  (head),
      .count_o (q_count),
      .full_o  (q_full),
      .empty_o (q_empty)
   );

   a_no_push_full: assert property (
      @(posedge clk) disable iff (rst) !(keep && q_full));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order, fixed-latency memory.
// DEPTH=3 lets one-cycle memory sustain one instruction per cycle.
module tb_fetch_unit;

   localparam int D = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b0;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;
   logic        if_ready = 1'b0;

   int   n_chk = 0;
   int   n_fail = 0;
   int   lat = 1;
   logic inj = 1'b0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0), .DEPTH(D)) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_instr       (if_instr),
      .if_ready       (if_ready)
   );

   function automatic logic [31:0] mdata(input logic [31:0] a);
      return a ^ 32'hC0DE_5EED;
   endfunction

   // memory model: accepted address returns lat cycles later, in order
   typedef struct {
      logic [31:0] a;
      int          due;
   } pend_t;

   pend_t       pend[$];
   logic        acc_q = 1'b0;
   logic [31:0] acc_a = '0;
   int          cyc = 0;

   always @(posedge clk) begin
      acc_q <= !rst && imem_req_valid && imem_req_ready;
      acc_a <= imem_req_addr;
   end

   always @(negedge clk) begin
      cyc = cyc + 1;
      if (rst) begin
         pend.delete();
         imem_rsp_valid = 1'b0;
      end else begin
         if (acc_q) pend.push_back('{a: acc_a, due: cyc + lat - 1});
         if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mdata(pend[0].a);
            void'(pend.pop_front());
         end else begin
            imem_rsp_valid = inj;
            imem_rsp_data  = 32'hBAD0_BAD0;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset(input int l);
      @(negedge clk);
      rst = 1'b1;
      redirect_valid = 1'b0;
      if_ready = 1'b0;
      imem_req_ready = 1'b0;
      inj = 1'b0;
      lat = l;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      bit          ri;
      bit          rm;
      bit          ev;
      logic [31:0] ep;
      bit          erv;
      logic [31:0] ea;
   } vec_t;

   vec_t        tv[14];
   logic [31:0] wexp[3];
   int          n_acc;
   int          got;
   bit          found;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      tv[0]  = '{1, 1, 0, 32'd0,  1, 32'd0};
      tv[1]  = '{1, 1, 0, 32'd0,  1, 32'd4};
      tv[2]  = '{1, 1, 1, 32'd0,  1, 32'd8};
      tv[3]  = '{1, 1, 1, 32'd4,  1, 32'd12};
      tv[4]  = '{1, 1, 1, 32'd8,  1, 32'd16};
      tv[5]  = '{1, 1, 1, 32'd12, 1, 32'd20};
      tv[6]  = '{0, 1, 1, 32'd16, 1, 32'd24};
      tv[7]  = '{0, 1, 1, 32'd16, 0, 32'd0};
      tv[8]  = '{0, 1, 1, 32'd16, 0, 32'd0};
      tv[9]  = '{0, 1, 1, 32'd16, 0, 32'd0};
      tv[10] = '{1, 1, 1, 32'd16, 0, 32'd0};
      tv[11] = '{1, 1, 1, 32'd20, 1, 32'd28};
      tv[12] = '{1, 1, 1, 32'd24, 1, 32'd32};
      tv[13] = '{1, 1, 1, 32'd28, 1, 32'd36};
      wexp[0] = 32'hFFFF_FFF8;
      wexp[1] = 32'hFFFF_FFFC;
      wexp[2] = 32'h0000_0000;

      // values while reset is held
      #1;
      chk("rst req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst if_valid", 32'(if_valid), 32'd0);
      chk("rst if_pc", if_pc, 32'd0);
      chk("rst if_instr", if_instr, 32'd0);

      // streaming and stall table
      do_reset(1);
      for (int i = 0; i < 14; i++) begin
         if (i > 0) @(negedge clk);
         if_ready = tv[i].ri;
         imem_req_ready = tv[i].rm;
         #1;
         chk($sformatf("vec%0d req_valid", i),
             32'(imem_req_valid), 32'(tv[i].erv));
         if (tv[i].erv)
            chk($sformatf("vec%0d req_addr", i), imem_req_addr, tv[i].ea);
         chk($sformatf("vec%0d if_valid", i),
             32'(if_valid), 32'(tv[i].ev));
         if (tv[i].ev) begin
            chk($sformatf("vec%0d if_pc", i), if_pc, tv[i].ep);
            chk($sformatf("vec%0d if_instr", i), if_instr, mdata(tv[i].ep));
         end
      end

      // stall from reset: only DEPTH requests, head held, no loss
      do_reset(1);
      if_ready = 1'b0;
      imem_req_ready = 1'b1;
      n_acc = 0;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         #1;
         if (imem_req_valid && imem_req_ready) n_acc++;
      end
      chk("stall accepted", 32'(n_acc), 32'(D));
      chk("stall req_valid", 32'(imem_req_valid), 32'd0);
      chk("stall if_valid", 32'(if_valid), 32'd1);
      chk("stall if_pc", if_pc, 32'd0);
      if_ready = 1'b1;
      for (int j = 1; j < 4; j++) begin
         @(negedge clk);
         #1;
         chk($sformatf("release%0d if_valid", j), 32'(if_valid), 32'd1);
         chk($sformatf("release%0d if_pc", j), if_pc, 32'(4 * j));
         chk($sformatf("release%0d if_instr", j), if_instr,
             mdata(32'(4 * j)));
      end

      // redirect with two responses in flight
      do_reset(3);
      if_ready = 1'b1;
      imem_req_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      imem_req_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0103;
      #1;
      chk("redir req_valid", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
      redirect_valid = 1'b0;
      imem_req_ready = 1'b1;
      #1;
      chk("redir next req_valid", 32'(imem_req_valid), 32'd1);
      chk("redir next addr", imem_req_addr, 32'h0000_0100);
      found = 1'b0;
      for (int k = 0; k < 12 && !found; k++) begin
         @(negedge clk);
         #1;
         if (if_valid) found = 1'b1;
      end
      chk("redir if_valid seen", 32'(found), 32'd1);
      chk("redir first if_pc", if_pc, 32'h0000_0100);
      chk("redir first if_instr", if_instr, mdata(32'h0000_0100));
      @(negedge clk);
      #1;
      chk("redir second if_pc", if_pc, 32'h0000_0104);

      // redirect coincident with a response and a pop
      do_reset(1);
      if_ready = 1'b1;
      imem_req_ready = 1'b1;
      repeat (4) @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0200;
      #1;
      chk("coinc head present", 32'(if_valid), 32'd1);
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      chk("coinc queue empty", 32'(if_valid), 32'd0);
      chk("coinc next addr", imem_req_addr, 32'h0000_0200);
      @(negedge clk);
      #1;
      chk("coinc still empty", 32'(if_valid), 32'd0);
      @(negedge clk);
      #1;
      chk("coinc first if_valid", 32'(if_valid), 32'd1);
      chk("coinc first if_pc", if_pc, 32'h0000_0200);

      // address wrap past the top of memory
      do_reset(1);
      if_ready = 1'b1;
      imem_req_ready = 1'b1;
      repeat (2) @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFF8;
      @(negedge clk);
      redirect_valid = 1'b0;
      got = 0;
      for (int k = 0; k < 12 && got < 3; k++) begin
         #1;
         if (if_valid) begin
            chk($sformatf("wrap%0d if_pc", got), if_pc, wexp[got]);
            chk($sformatf("wrap%0d if_instr", got), if_instr,
                mdata(wexp[got]));
            got++;
         end
         @(negedge clk);
      end
      chk("wrap count", 32'(got), 32'd3);

      // asynchronous reset in the middle of a burst
      do_reset(1);
      if_ready = 1'b1;
      imem_req_ready = 1'b1;
      repeat (4) @(negedge clk);
      #1;
      chk("arst pre if_valid", 32'(if_valid), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("arst req_valid", 32'(imem_req_valid), 32'd0);
      chk("arst if_valid", 32'(if_valid), 32'd0);
      chk("arst if_pc", if_pc, 32'd0);
      chk("arst if_instr", if_instr, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("arst first req_valid", 32'(imem_req_valid), 32'd1);
      chk("arst first addr", imem_req_addr, 32'd0);
      repeat (2) @(negedge clk);
      #1;
      chk("arst first if_pc", if_pc, 32'd0);
      chk("arst first if_valid", 32'(if_valid), 32'd1);

      // response with nothing outstanding is ignored
      do_reset(1);
      if_ready = 1'b1;
      imem_req_ready = 1'b0;
      #1;
      inj = 1'b1;
      @(negedge clk);
      #1;
      inj = 1'b0;
      chk("viol if_valid", 32'(if_valid), 32'd0);
      @(negedge clk);
      #1;
      chk("viol if_valid after", 32'(if_valid), 32'd0);
      chk("viol req_valid", 32'(imem_req_valid), 32'd1);
      chk("viol req_addr", imem_req_addr, 32'd0);
      imem_req_ready = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 6 && !found; k++) begin
         @(negedge clk);
         #1;
         if (if_valid) found = 1'b1;
      end
      chk("viol if_valid seen", 32'(found), 32'd1);
      chk("viol if_pc", if_pc, 32'd0);
      chk("viol if_instr", if_instr, mdata(32'd0));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-002 Parameter DEPTH, default 2, sets instruction-queue entries and the maximum number of in-flight requests (legal values 2..4).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 redirect_valid  in  1  decode/execute branch, jump or trap redirect request.
REQ-006 redirect_pc  in  32  new fetch address; bits [1:0] are ignored and treated as 0.
REQ-007 imem_req_valid  out  1  fetch request valid.
REQ-008 imem_req_addr  out  32  fetch address.
REQ-009 imem_req_ready  in  1  memory accepts the request this cycle.
REQ-010 imem_rsp_valid  in  1  response valid; responses return in order, at least 1 cycle after acceptance.
REQ-011 imem_rsp_data  in  32  instruction word.
REQ-012 if_valid  out  1  queue head holds a valid instruction.
REQ-013 if_pc  out  32  PC of the queue head.
REQ-014 if_instr  out  32  instruction of the queue head.
REQ-015 if_ready  in  1  downstream (IF/ID register) accepts the head this cycle.

Function
REQ-016 A request is accepted when imem_req_valid && imem_req_ready; a pop occurs when if_valid && if_ready.
REQ-017 imem_req_valid SHALL be 1 iff !redirect_valid && (queue_count + outstanding) < DEPTH.
REQ-018 imem_req_addr SHALL equal fetch_pc; fetch_pc += 4 on each accepted request and wraps from 32'hFFFF_FFFC to 32'h0.
REQ-019 outstanding SHALL increment on acceptance, decrement on imem_rsp_valid, and be unchanged when both occur in the same cycle.
REQ-020 rsp_pc tracks the PC of the next expected kept response, increments by 4 on each kept response, and wraps like fetch_pc.
REQ-021 A kept response SHALL write {rsp_pc, imem_rsp_data} to the queue tail; it is visible on if_* the following cycle.
REQ-022 Latency: request accepted in cycle N, response in cycle M (M >= N+1), if_valid no earlier than cycle M+1.
REQ-023 if_pc, if_instr and if_valid SHALL be driven directly from the queue head, with no combinational path from imem_rsp_*.
REQ-024 A push and a pop in the same cycle SHALL both take effect; the credit rule in REQ-017 guarantees that a push never meets a full queue.
REQ-025 On redirect_valid, at the clock edge: queue cleared; any pop that cycle ignored; fetch_pc <= rsp_pc <= {redirect_pc[31:2], 2'b00}; discard_cnt <= outstanding minus (1 if imem_rsp_valid that cycle).
REQ-026 While discard_cnt > 0, each imem_rsp_valid SHALL be dropped and SHALL decrement discard_cnt; it is neither queued nor does it advance rsp_pc.
REQ-027 A response arriving in the redirect cycle SHALL be discarded.
REQ-028 Back-to-back redirects: the last one wins; discard_cnt is recomputed from the current outstanding count each time.
REQ-029 New requests MAY issue while discard_cnt > 0; the credit rule still counts responses that will be discarded.
REQ-030 An imem_rsp_valid with outstanding == 0 is a protocol violation and SHALL be ignored; no counter may underflow.

Reset
REQ-031 While rst is high: fetch_pc = rsp_pc = RESET_PC; outstanding = discard_cnt = queue_count = 0; if_valid = 0; imem_req_valid = 0; if_pc = if_instr = 0.
REQ-032 The first request (addr RESET_PC) SHALL assert in the first cycle after rst deasserts.
REQ-033 Reset mid-operation SHALL abandon all in-flight requests; the memory side must be reset concurrently.

Structure
REQ-034 Shared package fetch_pkg SHALL hold XLEN=32, INSTR_W=32, the RESET_PC default, the DEPTH default, and the counter width localparam $clog2(DEPTH+1).
REQ-035 The queue SHALL be a sub-module fetch_fifo: synchronous, DEPTH x 64-bit {pc, instr}, with push, pop, clear, count, full and empty.

Verification
REQ-036 Reset release, mem always ready, 1-cycle latency, if_ready=1 -> addresses 0,4,8,...; if_pc 0,4,8 each with its matching word; sustained 1 instr/cycle after 2-cycle fill.
REQ-037 if_ready=0 for 10 cycles -> exactly DEPTH requests accepted, then imem_req_valid=0; if_valid held with if_pc=0; no loss on release.
REQ-038 Redirect to 32'h0000_0103 with 2 outstanding -> next request addr 32'h100; next 2 responses dropped; first if_pc after redirect = 32'h100.
REQ-039 Redirect coincident with a response and a pop -> that response discarded; queue empty next cycle; discard_cnt = outstanding-1.
REQ-040 Redirect to 32'hFFFF_FFF8 -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-041 rst asserted asynchronously mid-burst -> all outputs reach reset values immediately; first post-reset request addr = RESET_PC.
